ofdm_frame_extractor: RTL and testbench

//   Sits directly downstream of the Schmidl-Cox detector, in the ce_clk domain, inside the OFDM RX chain.

---
 rtl/ofdm_frame_extractor_if.sv | 19 +
 rtl/ofdm_frame_extractor.sv | 178 +++++++++++++++++
 tb/tb_ofdm_frame_extractor.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_frame_extractor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ofdm_frame_extractor_if                                                    |
// | AXI-Stream style sample bus with master/slave views.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ofdm_frame_extractor_if #(
  parameter int ITEM_W = 32
);
  logic [ITEM_W-1:0] tdata;
  logic              tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/ofdm_frame_extractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ofdm_frame_extractor                                                       |
// | Cuts flagged frames into CP-stripped symbols, one packet per symbol.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ofdm_frame_extractor #(
  parameter int ITEM_W = 32,
  parameter int LEN_W  = 16,
  parameter int SYM_W  = 8,
  parameter int CNT_W  = 16
) (
  input  wire                ce_clk,
  input  wire                ce_rst,
  input  wire [LEN_W-1:0]    cfg_fft_len,
  input  wire [LEN_W-1:0]    cfg_cp_len,
  input  wire [SYM_W-1:0]    cfg_num_symbols,
  ofdm_frame_extractor_if.slave  s_axis,
  ofdm_frame_extractor_if.master m_axis,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_count,
  output logic [CNT_W-1:0]   drop_count
);

  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CP   = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              r_state,     w_state;
  logic [LEN_W-1:0]    r_samp_cnt,  w_samp_cnt;
  logic [SYM_W-1:0]    r_sym_cnt,   w_sym_cnt;
  logic [LEN_W-1:0]    r_fft_len,   w_fft_len;
  logic [LEN_W-1:0]    r_cp_len,    w_cp_len;
  logic [SYM_W-1:0]    r_num_sym,   w_num_sym;
  logic [CNT_W-1:0]    r_frame_cnt, w_frame_cnt;
  logic [CNT_W-1:0]    r_drop_cnt,  w_drop_cnt;
  logic [ITEM_W-1:0]   r_tdata,     w_tdata;
  logic                r_tlast,     w_tlast;
  logic                r_tuser,     w_tuser;
  logic                r_tvalid,    w_tvalid;

  logic                w_ready;
  logic                w_beat;
  logic                w_fwd;
  logic                w_eos;
  logic                w_last_sym;

  assign w_ready = (r_state == S_DATA) ? (~r_tvalid | m_axis.tready) : 1'b1;
  assign w_beat  = s_axis.tvalid & w_ready;

  always_comb begin
    w_state     = r_state;
    w_samp_cnt  = r_samp_cnt;
    w_sym_cnt   = r_sym_cnt;
    w_fft_len   = r_fft_len;
    w_cp_len    = r_cp_len;
    w_num_sym   = r_num_sym;
    w_frame_cnt = r_frame_cnt;
    w_drop_cnt  = r_drop_cnt;
    w_tvalid    = r_tvalid & ~m_axis.tready;
    w_tdata     = r_tdata;
    w_tlast     = r_tlast;
    w_tuser     = r_tuser;
    w_fwd       = 1'b0;
    w_eos       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_beat && s_axis.tuser && (cfg_num_symbols != '0)) begin
          w_fft_len = cfg_fft_len;
          w_cp_len  = cfg_cp_len;
          w_num_sym = cfg_num_symbols;
          w_sym_cnt = '0;
          if (cfg_cp_len == '0) begin
            w_fwd      = 1'b1;
            w_samp_cnt = c_len_one;
            w_state    = S_DATA;
            w_eos      = (cfg_fft_len == c_len_one);
          end else if (cfg_cp_len == c_len_one) begin
            // A one-sample prefix is fully consumed by the start beat itself
            w_samp_cnt = '0;
            w_state    = S_DATA;
          end else begin
            w_samp_cnt = c_len_one;
            w_state    = S_CP;
          end
        end
      end
      S_CP: begin
        if (w_beat) begin
          if (r_samp_cnt == r_cp_len - c_len_one) begin
            w_samp_cnt = '0;
            w_state    = S_DATA;
          end else begin
            w_samp_cnt = r_samp_cnt + c_len_one;
          end
        end
      end
      S_DATA: begin
        if (w_beat) begin
          w_fwd      = 1'b1;
          w_samp_cnt = r_samp_cnt + c_len_one;
          w_eos      = (r_samp_cnt == r_fft_len - c_len_one);
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_last_sym = (w_sym_cnt == w_num_sym - SYM_W'(1));

    if (w_beat && s_axis.tuser && (r_state != S_IDLE))
      w_drop_cnt = r_drop_cnt + CNT_W'(1);

    if (w_fwd) begin
      w_tvalid = 1'b1;
      w_tdata  = s_axis.tdata;
      w_tlast  = w_eos;
      w_tuser  = w_eos & w_last_sym;
    end

    // Symbol boundary: either close the frame or move on to the next prefix
    if (w_eos) begin
      w_samp_cnt = '0;
      if (w_last_sym) begin
        w_frame_cnt = r_frame_cnt + CNT_W'(1);
        w_state     = S_IDLE;
      end else begin
        w_sym_cnt = w_sym_cnt + SYM_W'(1);
        w_state   = (w_cp_len == '0) ? S_DATA : S_CP;
      end
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      r_state     <= S_IDLE;
      r_samp_cnt  <= '0;
      r_sym_cnt   <= '0;
      r_fft_len   <= '0;
      r_cp_len    <= '0;
      r_num_sym   <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_tvalid    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_samp_cnt  <= w_samp_cnt;
      r_sym_cnt   <= w_sym_cnt;
      r_fft_len   <= w_fft_len;
      r_cp_len    <= w_cp_len;
      r_num_sym   <= w_num_sym;
      r_frame_cnt <= w_frame_cnt;
      r_drop_cnt  <= w_drop_cnt;
      r_tdata     <= w_tdata;
      r_tlast     <= w_tlast;
      r_tuser     <= w_tuser;
      r_tvalid    <= w_tvalid;
    end
  end

  assign s_axis.tready = w_ready;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tuser  = r_tuser;
  assign m_axis.tvalid = r_tvalid;
  assign busy          = (r_state != S_IDLE);
  assign frame_count   = r_frame_cnt;
  assign drop_count    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_frame_extractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ofdm_frame_extractor                                                    |
// | Directed frames checked against a position-arithmetic frame model.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ofdm_frame_extractor;

  logic        ce_clk = 1'b0;
  logic        ce_rst;
  logic [15:0] cfg_fft_len;
  logic [15:0] cfg_cp_len;
  logic [7:0]  cfg_num_symbols;
  logic        busy;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  ofdm_frame_extractor_if #(.ITEM_W(32)) s_if ();
  ofdm_frame_extractor_if #(.ITEM_W(32)) m_if ();

  ofdm_frame_extractor #(
    .ITEM_W(32), .LEN_W(16), .SYM_W(8), .CNT_W(16)
  ) dut (
    .ce_clk          (ce_clk),
    .ce_rst          (ce_rst),
    .cfg_fft_len     (cfg_fft_len),
    .cfg_cp_len      (cfg_cp_len),
    .cfg_num_symbols (cfg_num_symbols),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .busy            (busy),
    .frame_count     (frame_count),
    .drop_count      (drop_count)
  );

  always #5 ce_clk = ~ce_clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit gaps     = 1'b0;
  bit rnd_rdy  = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame model: each accepted beat is classified purely by its offset in the frame
  logic [33:0] mq[$];
  logic [33:0] cap[$];
  bit          m_in_frame = 1'b0;
  int          m_fft, m_cp, m_num, m_total, m_pos;
  logic [15:0] m_frame = '0;
  logic [15:0] m_drop  = '0;
  bit          prev_stall = 1'b0;
  logic [33:0] held;

  task automatic model_beat(input logic [31:0] d, input logic f);
    int  per;
    int  k;
    bit  last;
    if (!m_in_frame) begin
      if (!(f && cfg_num_symbols != 8'd0)) return;
      m_fft      = int'(cfg_fft_len);
      m_cp       = int'(cfg_cp_len);
      m_num      = int'(cfg_num_symbols);
      m_total    = m_num * (m_cp + m_fft);
      m_pos      = 0;
      m_in_frame = 1'b1;
    end else if (f) begin
      m_drop = m_drop + 16'd1;
    end
    per = m_cp + m_fft;
    k   = m_pos % per;
    if (k >= m_cp) begin
      last = (k == per - 1);
      mq.push_back({last && (m_pos == m_total - 1), last, d});
    end
    m_pos++;
    if (m_pos == m_total) begin
      m_in_frame = 1'b0;
      m_frame    = m_frame + 16'd1;
    end
  endtask

  function automatic bit model_in_data();
    if (!m_in_frame) return 1'b0;
    return (m_pos % (m_cp + m_fft)) >= m_cp;
  endfunction

  always @(negedge ce_clk) begin
    logic [33:0] act;
    logic [33:0] exp;
    logic        exp_rdy;
    act = {m_if.tuser, m_if.tlast, m_if.tdata};
    if (ce_rst) begin
      mq.delete();
      m_in_frame = 1'b0;
      m_frame    = '0;
      m_drop     = '0;
      prev_stall = 1'b0;
    end else begin
      chk(frame_count == m_frame, "frame_count", 64'(frame_count), 64'(m_frame));
      chk(drop_count == m_drop, "drop_count", 64'(drop_count), 64'(m_drop));
      chk(busy == m_in_frame, "busy", 64'(busy), 64'(m_in_frame));
      exp_rdy = model_in_data() ? (~m_if.tvalid | m_if.tready) : 1'b1;
      chk(s_if.tready == exp_rdy, "s_tready", 64'(s_if.tready), 64'(exp_rdy));
      if (prev_stall)
        chk(m_if.tvalid && act == held, "stall_hold", {29'd0, m_if.tvalid, act}, {30'd1, held});
      if (m_if.tvalid && m_if.tready) begin
        if (mq.size() == 0) begin
          chk(1'b0, "unexpected_out", 64'(act), 64'd0);
        end else begin
          exp = mq.pop_front();
          chk(act == exp, "out_beat", 64'(act), 64'(exp));
        end
        cap.push_back(act);
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      held       = act;
      if (s_if.tvalid && s_if.tready) model_beat(s_if.tdata, s_if.tuser);
    end
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge ce_clk);
      #1;
      m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [31:0] d, input logic f);
    int n;
    bit acc;
    if (gaps && $urandom_range(0, 1) == 1) begin
      s_if.tvalid = 1'b0;
      @(posedge ce_clk);
      #1;
    end
    s_if.tdata  = d;
    s_if.tuser  = f;
    s_if.tvalid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge ce_clk);
      acc = s_if.tready;
      @(posedge ce_clk);
      #1;
      n++;
    end
    if (!acc) chk(1'b0, "send_timeout", 64'(n), 64'd1000);
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic ramp(input int first, input int last, input int f1, input int f2, input int f3);
    for (int i = first; i <= last; i++)
      send(32'(i), (i == f1) || (i == f2) || (i == f3));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || m_if.tvalid) && n < 500) begin
      @(posedge ce_clk);
      #1;
      n++;
    end
    chk(n < 500, "drain_timeout", 64'(n), 64'd500);
  endtask

  // Literal layout of an fft=8/cp=2/syms=2 frame flagged at sample `flag`
  task automatic check_frame82(input int base, input int flag, input string nm);
    logic [31:0] d;
    logic        l;
    logic        u;
    for (int i = 0; i < 16; i++) begin
      d = 32'(flag + 2 + i + ((i >= 8) ? 2 : 0));
      l = (i == 7) || (i == 15);
      u = (i == 15);
      chk(cap[base + i] == {u, l, d}, nm, 64'(cap[base + i]), 64'({u, l, d}));
    end
  endtask

  task automatic set_cfg(input int fft, input int cp, input int syms);
    cfg_fft_len     = 16'(fft);
    cfg_cp_len      = 16'(cp);
    cfg_num_symbols = 8'(syms);
  endtask

  initial begin
    ce_rst      = 1'b1;
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b0;
    set_cfg(8, 2, 2);
    repeat (3) @(posedge ce_clk);
    #1;
    chk(m_if.tvalid == 1'b0, "rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk({m_if.tuser, m_if.tlast, m_if.tdata} == 34'd0, "rst_out", 64'({m_if.tuser, m_if.tlast, m_if.tdata}), 64'd0);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(frame_count == 16'd0 && drop_count == 16'd0, "rst_counts", {frame_count, drop_count}, 64'd0);
    @(negedge ce_clk);
    #2 ce_rst = 1'b0;
    @(posedge ce_clk);
    #1;

    // Basic frame
    cap.delete();
    ramp(0, 63, 10, -1, -1);
    drain();
    chk(cap.size() == 16, "t1_count", 64'(cap.size()), 64'd16);
    check_frame82(0, 10, "t1_beat");
    chk(frame_count == 16'd1, "t1_frames", 64'(frame_count), 64'd1);

    // Same frame with back-pressure and input gaps
    cap.delete();
    gaps    = 1'b1;
    rnd_rdy = 1'b1;
    ramp(0, 63, 10, -1, -1);
    drain();
    gaps    = 1'b0;
    rnd_rdy = 1'b0;
    chk(cap.size() == 16, "t2_count", 64'(cap.size()), 64'd16);
    check_frame82(0, 10, "t2_beat");
    chk(frame_count == 16'd2, "t2_frames", 64'(frame_count), 64'd2);

    // No cyclic prefix: contiguous output
    cap.delete();
    set_cfg(4, 0, 3);
    ramp(0, 15, 0, -1, -1);
    drain();
    chk(cap.size() == 12, "t3_count", 64'(cap.size()), 64'd12);
    for (int i = 0; i < 12; i++)
      chk(cap[i] == {1'(i == 11), 1'(i % 4 == 3), 32'(i)}, "t3_beat", 64'(cap[i]),
          64'({1'(i == 11), 1'(i % 4 == 3), 32'(i)}));
    chk(frame_count == 16'd3, "t3_frames", 64'(frame_count), 64'd3);

    // Flag inside a frame is dropped; flag right after the frame restarts
    cap.delete();
    set_cfg(8, 2, 2);
    ramp(0, 49, 10, 15, 30);
    drain();
    chk(cap.size() == 32, "t4_count", 64'(cap.size()), 64'd32);
    check_frame82(0, 10, "t4_beat_a");
    check_frame82(16, 30, "t4_beat_b");
    chk(drop_count == 16'd1, "t4_drops", 64'(drop_count), 64'd1);
    chk(frame_count == 16'd5, "t4_frames", 64'(frame_count), 64'd5);

    // Config change mid-frame only affects the next frame
    cap.delete();
    for (int i = 0; i <= 59; i++) begin
      if (i == 5) cfg_fft_len = 16'd16;
      send(32'(i), (i == 0) || (i == 20));
    end
    drain();
    chk(cap.size() == 48, "t5_count", 64'(cap.size()), 64'd48);
    check_frame82(0, 0, "t5_beat_a");
    chk(cap[16] == {2'b00, 32'd22}, "t5_first16", 64'(cap[16]), 64'({2'b00, 32'd22}));
    chk(cap[31] == {2'b01, 32'd37}, "t5_sym0_last", 64'(cap[31]), 64'({2'b01, 32'd37}));
    chk(cap[47] == {2'b11, 32'd55}, "t5_frame_last", 64'(cap[47]), 64'({2'b11, 32'd55}));
    chk(frame_count == 16'd7, "t5_frames", 64'(frame_count), 64'd7);

    // Zero-symbol frames are ignored entirely
    cap.delete();
    set_cfg(8, 2, 0);
    ramp(100, 120, 100, 110, -1);
    drain();
    chk(cap.size() == 0, "t5_zero_out", 64'(cap.size()), 64'd0);
    chk(frame_count == 16'd7 && drop_count == 16'd1, "t5_zero_counts", {frame_count, drop_count}, {16'd7, 16'd1});

    // Asynchronous reset in the middle of symbol 0 data
    set_cfg(8, 2, 2);
    ramp(0, 5, 0, -1, -1);
    ce_rst = 1'b1;
    #1;
    chk(m_if.tvalid == 1'b0, "t6_tvalid", 64'(m_if.tvalid), 64'd0);
    chk(busy == 1'b0, "t6_busy", 64'(busy), 64'd0);
    chk(frame_count == 16'd0 && drop_count == 16'd0, "t6_counts", {frame_count, drop_count}, 64'd0);
    @(negedge ce_clk);
    #2 ce_rst = 1'b0;
    @(posedge ce_clk);
    #1;
    cap.delete();
    ramp(0, 29, 0, -1, -1);
    drain();
    chk(cap.size() == 16, "t6_count", 64'(cap.size()), 64'd16);
    check_frame82(0, 0, "t6_beat");
    chk(frame_count == 16'd1, "t6_frames", 64'(frame_count), 64'd1);

    repeat (2) @(posedge ce_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
